// File: rtl/fft_buf_pkg.sv
// Shared types and helpers for the FFT frame buffer.
package fft_buf_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DRAIN
  } state_t;

  function automatic int unsigned addr_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/frame_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port.
module frame_ram #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fft_frame_buffer.sv
// Circular-RAM frame buffer: collects samples and streams N-sample frames, oldest first,
// with optional continuous overlapped capture and sticky lost-sample flag.
module fft_frame_buffer
  import fft_buf_pkg::*;
#(
  parameter int unsigned N      = 1024,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned HOP    = N
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              continuous,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sof,
  output logic              out_eof,
  output logic              start_fft,
  output logic              overrun,
  output logic              busy
);

  localparam int unsigned ADDR_W = addr_w(N);
  localparam logic [ADDR_W:0] N_CNT    = (ADDR_W+1)'(N);
  localparam logic [ADDR_W:0] HOP_CNT  = (ADDR_W+1)'(HOP);
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(N - 1);

  if (N < 4 || (N & (N - 1)) != 0 || HOP < 1 || HOP > N) begin : g_param_check
    $error("fft_frame_buffer: N must be a power of 2 >= 4 and HOP in 1..N");
  end

  state_t state, state_nx;

  logic [ADDR_W-1:0] wr_ptr, wr_ptr_inc, rd_base, raddr;
  logic [ADDR_W:0]   new_cnt, new_cnt_inc, need, rd_cnt, iss, ld_cnt;
  logic              wr_en, drop, re, q_valid, accept, last_accept, out_load, enter_drain;
  logic [DATA_W-1:0] q;

  assign accept      = out_valid & out_ready;
  assign last_accept = accept & out_eof;
  assign out_load    = q_valid & (~out_valid | out_ready);
  assign busy        = (state != IDLE);

  // In DRAIN the j-th accepted write lands at wr_ptr == rd_base + new_cnt, so it is safe
  // exactly when that slot has already been handed to the consumer.
  always_comb begin
    wr_en = 1'b0;
    drop  = 1'b0;
    if (state == FILL) begin
      wr_en = in_valid;
    end else if (state == DRAIN && in_valid && continuous) begin
      if (new_cnt < rd_cnt) wr_en = 1'b1;
      else                  drop  = 1'b1;
    end
  end

  assign new_cnt_inc = new_cnt + {{ADDR_W{1'b0}}, wr_en};
  assign wr_ptr_inc  = wr_ptr + {{(ADDR_W-1){1'b0}}, wr_en};

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (arm) state_nx = FILL;
      FILL:  if (wr_en && new_cnt_inc >= need) state_nx = DRAIN;
      DRAIN: begin
        if (last_accept) begin
          if (!continuous)               state_nx = IDLE;
          else if (new_cnt_inc >= HOP_CNT) state_nx = DRAIN;
          else                           state_nx = FILL;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign enter_drain = (state_nx == DRAIN) && ((state != DRAIN) || last_accept);

  // First read is issued on the entry edge so the output register fills one cycle later.
  always_comb begin
    re    = 1'b0;
    raddr = rd_base + iss[ADDR_W-1:0];
    if (enter_drain) begin
      re    = 1'b1;
      raddr = wr_ptr_inc;
    end else if (state == DRAIN && !last_accept && iss < N_CNT && (!q_valid || out_load)) begin
      re = 1'b1;
    end
  end

  frame_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (N),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (in_data),
    .re    (re),
    .raddr (raddr),
    .rdata (q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_base   <= '0;
      new_cnt   <= '0;
      need      <= '0;
      rd_cnt    <= '0;
      iss       <= '0;
      ld_cnt    <= '0;
      q_valid   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      start_fft <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_nx;
      start_fft <= 1'b0;
      if (wr_en) wr_ptr <= wr_ptr_inc;
      if (drop)  overrun <= 1'b1;

      if (state == IDLE && arm) begin
        new_cnt <= '0;
        need    <= N_CNT;
        overrun <= 1'b0;
      end else if (enter_drain) begin
        new_cnt <= '0;
      end else begin
        new_cnt <= new_cnt_inc;
      end

      if (last_accept && state_nx == FILL) need <= HOP_CNT;

      if (enter_drain) begin
        rd_base <= wr_ptr_inc;
        rd_cnt  <= '0;
        iss     <= {{ADDR_W{1'b0}}, 1'b1};
        ld_cnt  <= '0;
        q_valid <= 1'b1;
      end else if (state == DRAIN) begin
        iss     <= iss + {{ADDR_W{1'b0}}, re};
        rd_cnt  <= rd_cnt + {{ADDR_W{1'b0}}, accept};
        ld_cnt  <= ld_cnt + {{ADDR_W{1'b0}}, out_load};
        q_valid <= re | (q_valid & ~out_load);
      end else begin
        q_valid <= 1'b0;
      end

      if (out_load) begin
        out_valid <= 1'b1;
        out_data  <= q;
        out_sof   <= (ld_cnt == '0);
        out_eof   <= (ld_cnt == LAST_IDX);
        start_fft <= (ld_cnt == '0);
      end else if (accept) begin
        out_valid <= 1'b0;
        out_sof   <= 1'b0;
        out_eof   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fft_frame_buffer.sv
// Directed bench: one N=8 instance with HOP=8 and one with HOP=4.
module tb_fft_frame_buffer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        arm_a, cont_a, iv_a, ordy_a, ov_a, sof_a, eof_a, sf_a, ovr_a, busy_a;
  logic [31:0] id_a, od_a;
  logic        arm_b, cont_b, iv_b, ordy_b, ov_b, sof_b, eof_b, sf_b, ovr_b, busy_b;
  logic [31:0] id_b, od_b;

  fft_frame_buffer #(.N(8), .DATA_W(32), .HOP(8)) u_dut_a (
    .clk(clk), .rst(rst), .arm(arm_a), .continuous(cont_a), .in_valid(iv_a), .in_data(id_a),
    .out_valid(ov_a), .out_ready(ordy_a), .out_data(od_a), .out_sof(sof_a), .out_eof(eof_a),
    .start_fft(sf_a), .overrun(ovr_a), .busy(busy_a)
  );

  fft_frame_buffer #(.N(8), .DATA_W(32), .HOP(4)) u_dut_b (
    .clk(clk), .rst(rst), .arm(arm_b), .continuous(cont_b), .in_valid(iv_b), .in_data(id_b),
    .out_valid(ov_b), .out_ready(ordy_b), .out_data(od_b), .out_sof(sof_b), .out_eof(eof_b),
    .start_fft(sf_b), .overrun(ovr_b), .busy(busy_b)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] got [0:31];
  logic        got_sof [0:31];
  logic        got_eof [0:31];
  int          n_got, sf_count, sf_bad, stable_bad;
  bit          timed_out;

  task automatic idle_inputs();
    arm_a = 0; cont_a = 0; iv_a = 0; id_a = '0; ordy_a = 0;
    arm_b = 0; cont_b = 0; iv_b = 0; id_b = '0; ordy_b = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Drives one single-shot capture on instance A and records accepted beats (no checking).
  task automatic run_a(input logic [31:0] base, input int gap, input int mode, input int max_beats);
    int cyc, sent;
    logic pstall, ps, pe;
    logic [31:0] pd;
    n_got = 0; sf_count = 0; sf_bad = 0; stable_bad = 0; timed_out = 0;
    cyc = 0; sent = 0; pstall = 0; ps = 0; pe = 0; pd = '0;
    forever begin
      arm_a  = (cyc == 0);
      cont_a = 1'b0;
      ordy_a = (mode == 0) ? 1'b1 : ~cyc[0];
      if (cyc >= 1 && sent < 8 && ((cyc - 1) % gap) == 0) begin
        iv_a = 1'b1; id_a = base + sent; sent++;
      end else begin
        iv_a = 1'b0;
      end
      if (pstall && (!ov_a || od_a !== pd || sof_a !== ps || eof_a !== pe)) stable_bad++;
      if (sf_a) begin
        sf_count++;
        if (!(ov_a && sof_a)) sf_bad++;
      end
      if (ov_a && ordy_a) begin
        got[n_got] = od_a; got_sof[n_got] = sof_a; got_eof[n_got] = eof_a; n_got++;
      end
      pstall = ov_a && !ordy_a; pd = od_a; ps = sof_a; pe = eof_a;
      cyc++;
      if (n_got >= max_beats) break;
      if (cyc > 400) begin timed_out = 1; break; end
      @(negedge clk);
    end
    iv_a = 1'b0;
  endtask

  task automatic test_reset();
    vectors++;
    if ({ov_a, sof_a, eof_a, sf_a, ovr_a, busy_a} !== 6'b0 || od_a !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_a: flags=%b data=%0d expected flags=000000 data=0",
               {ov_a, sof_a, eof_a, sf_a, ovr_a, busy_a}, od_a);
    end
    vectors++;
    if ({ov_b, sof_b, eof_b, sf_b, ovr_b, busy_b} !== 6'b0 || od_b !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_b: flags=%b data=%0d expected flags=000000 data=0",
               {ov_b, sof_b, eof_b, sf_b, ovr_b, busy_b}, od_b);
    end
  endtask

  task automatic test_single_shot();
    logic [7:0] sm, em;
    run_a(32'd0, 2, 0, 8);
    vectors++;
    if (timed_out !== 1'b0) begin miscompares++; $display("FAIL single_timeout: beats=%0d expected 8", n_got); end
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (got[i] !== 32'(i)) begin
        miscompares++; $display("FAIL single_data[%0d]: got %0d expected %0d", i, got[i], i);
      end
      sm[i] = got_sof[i]; em[i] = got_eof[i];
    end
    vectors++;
    if (sm !== 8'h01) begin miscompares++; $display("FAIL single_sof: got %b expected 00000001", sm); end
    vectors++;
    if (em !== 8'h80) begin miscompares++; $display("FAIL single_eof: got %b expected 10000000", em); end
    vectors++;
    if (sf_count !== 1 || sf_bad !== 0) begin
      miscompares++; $display("FAIL single_start_fft: pulses=%0d misplaced=%0d expected 1/0", sf_count, sf_bad);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (busy_a !== 1'b0 || ov_a !== 1'b0) begin
      miscompares++; $display("FAIL single_idle: busy=%b out_valid=%b expected 0/0", busy_a, ov_a);
    end
  endtask

  task automatic test_stall();
    run_a(32'd0, 2, 1, 8);
    vectors++;
    if (timed_out !== 1'b0) begin miscompares++; $display("FAIL stall_timeout: beats=%0d expected 8", n_got); end
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (got[i] !== 32'(i)) begin
        miscompares++; $display("FAIL stall_data[%0d]: got %0d expected %0d", i, got[i], i);
      end
    end
    vectors++;
    if (stable_bad !== 0) begin miscompares++; $display("FAIL stall_stable: unstable cycles=%0d expected 0", stable_bad); end
    vectors++;
    if (sf_count !== 1 || sf_bad !== 0) begin
      miscompares++; $display("FAIL stall_start_fft: pulses=%0d misplaced=%0d expected 1/0", sf_count, sf_bad);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    run_a(32'd10, 1, 0, 3);
    @(negedge clk);
    vectors++;
    if (ov_a !== 1'b1 || od_a !== 32'd13) begin
      miscompares++; $display("FAIL midrst_beat4: valid=%b data=%0d expected 1/13", ov_a, od_a);
    end
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (ov_a !== 1'b0 || busy_a !== 1'b0 || ovr_a !== 1'b0) begin
      miscompares++; $display("FAIL midrst_outputs: valid=%b busy=%b overrun=%b expected 0/0/0", ov_a, busy_a, ovr_a);
    end
    rst = 1'b0;
    run_a(32'd50, 1, 0, 8);
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (got[i] !== 32'(50 + i)) begin
        miscompares++; $display("FAIL midrst_data[%0d]: got %0d expected %0d", i, got[i], 50 + i);
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_idle_input();
    for (int i = 0; i < 4; i++) begin
      iv_a = 1'b1; id_a = 32'hDEAD_0000 + 32'(i);
      @(negedge clk);
    end
    iv_a = 1'b0;
    vectors++;
    if (busy_a !== 1'b0 || ovr_a !== 1'b0) begin
      miscompares++; $display("FAIL idle_ignore: busy=%b overrun=%b expected 0/0", busy_a, ovr_a);
    end
    run_a(32'd0, 1, 0, 8);
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (got[i] !== 32'(i)) begin
        miscompares++; $display("FAIL idle_data[%0d]: got %0d expected %0d", i, got[i], i);
      end
    end
    vectors++;
    if (ovr_a !== 1'b0) begin miscompares++; $display("FAIL idle_overrun: got %b expected 0", ovr_a); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_continuous_overlap();
    int cyc, sent;
    logic [23:0] sm, em;
    bit to;
    cyc = 0; sent = 0; n_got = 0; to = 0;
    forever begin
      arm_b = (cyc == 0); cont_b = 1'b1; ordy_b = 1'b1;
      if (cyc >= 1 && sent < 16 && ((cyc - 1) % 4) == 0) begin
        iv_b = 1'b1; id_b = 32'(sent); sent++;
      end else begin
        iv_b = 1'b0;
      end
      if (ov_b && ordy_b) begin
        got[n_got] = od_b; got_sof[n_got] = sof_b; got_eof[n_got] = eof_b; n_got++;
      end
      cyc++;
      if (n_got >= 24) break;
      if (cyc > 600) begin to = 1; break; end
      @(negedge clk);
    end
    iv_b = 1'b0;
    vectors++;
    if (to) begin miscompares++; $display("FAIL overlap_timeout: beats=%0d expected 24", n_got); end
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 8; k++) begin
        vectors++;
        if (got[f*8 + k] !== 32'(4*f + k)) begin
          miscompares++;
          $display("FAIL overlap_data[f%0d,%0d]: got %0d expected %0d", f, k, got[f*8 + k], 4*f + k);
        end
      end
    end
    for (int i = 0; i < 24; i++) begin sm[i] = got_sof[i]; em[i] = got_eof[i]; end
    vectors++;
    if (sm !== 24'h010101 || em !== 24'h808080) begin
      miscompares++; $display("FAIL overlap_sof_eof: sof=%h eof=%h expected 010101/808080", sm, em);
    end
    vectors++;
    if (ovr_b !== 1'b0) begin miscompares++; $display("FAIL overlap_overrun: got %b expected 0", ovr_b); end
    do_reset();
  endtask

  task automatic test_overrun();
    int cyc;
    bit to;
    logic [31:0] exp;
    cyc = 0; n_got = 0; to = 0;
    forever begin
      arm_b  = (cyc == 0);
      cont_b = 1'b1;
      ordy_b = (cyc >= 12);
      iv_b   = (cyc >= 1);
      id_b   = (cyc <= 8) ? 32'(cyc - 1) : 32'(100 + cyc - 9);
      if (ov_b && ordy_b) begin got[n_got] = od_b; n_got++; end
      cyc++;
      if (n_got >= 16) break;
      if (cyc > 200) begin to = 1; break; end
      @(negedge clk);
    end
    iv_b = 1'b0;
    vectors++;
    if (to) begin miscompares++; $display("FAIL overrun_timeout: beats=%0d expected 16", n_got); end
    // Second frame: slot 7 still holds sample 7, slots 0..6 refilled by 104..110.
    for (int i = 0; i < 16; i++) begin
      exp = (i < 8) ? 32'(i) : (i == 8) ? 32'd7 : 32'(104 + i - 9);
      vectors++;
      if (got[i] !== exp) begin
        miscompares++; $display("FAIL overrun_data[%0d]: got %0d expected %0d", i, got[i], exp);
      end
    end
    vectors++;
    if (ovr_b !== 1'b1) begin miscompares++; $display("FAIL overrun_flag: got %b expected 1", ovr_b); end
    do_reset();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    do_reset();
    test_reset();
    test_single_shot();
    test_stall();
    test_reset_mid_frame();
    test_idle_input();
    test_continuous_overlap();
    test_overrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
